multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core subset: OP, OP-IMM, LOAD, STORE and BRANCH.
- Sequences fetch, decode, execute, memory and writeback by driving the enables and selects of the existing datapath: PC, IR, register file, ALU, immediate path and memories.
- Both memories are variable-latency with req/ready handshakes; each wait is bounded by a timeout.
- Illegal opcodes and memory timeouts drive a sticky trap state.

---
 rtl/multicycle_ctrl_if.sv | 51 +++++
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl (master) and the RV32I datapath.
// Counter outputs exist only when MULTICYCLE_PERF_CNT_EN is defined.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_en;
    logic        pc_en;
    logic        pc_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        alu_src_imm;
    logic        wb_sel;
    logic [1:0]  alu_op;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_dbg;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_we,
        output rf_we, alu_src_imm, wb_sel, alu_op,
        output trap, trap_cause, state_dbg, cycle_cnt, instret_cnt
    );
    modport slave (
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_we,
        input  rf_we, alu_src_imm, wb_sel, alu_op,
        input  trap, trap_cause, state_dbg, cycle_cnt, instret_cnt
    );
`else
    modport master (
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_we,
        output rf_we, alu_src_imm, wb_sel, alu_op,
        output trap, trap_cause, state_dbg
    );
    modport slave (
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_en, pc_en, pc_sel, dmem_req, dmem_we,
        input  rf_we, alu_src_imm, wb_sel, alu_op,
        input  trap, trap_cause, state_dbg
    );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with bounded memory waits and sticky trap.
// Optional perf counters: define MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_TRAP   = 3'b110
    } state_e;

    typedef enum logic [2:0] {
        C_NONE, C_OP, C_OPI, C_LD, C_ST, C_BR
    } cls_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [7:0] cnt_q, cnt_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;

    logic       imem_req, ir_en, pc_en, pc_sel;
    logic       dmem_req, dmem_we, rf_we;
    logic       alu_src_imm, wb_sel;
    logic [1:0] alu_op;

    logic       cnt_last;
    logic [7:0] cnt_inc;
    logic       op_r, op_i, op_ld, op_st, op_br;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    assign op_r  = (bus.opcode == 7'b0110011);
    assign op_i  = (bus.opcode == 7'b0010011);
    assign op_ld = (bus.opcode == 7'b0000011);
    assign op_st = (bus.opcode == 7'b0100011);
    assign op_br = (bus.opcode == 7'b1100011);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
            cnt_q   <= 8'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Wait counter defaults to clear; only a stalled FETCH/MEM advances it.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        cnt_d       = 8'd0;
        trap_d      = trap_q;
        cause_d     = cause_q;
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = 1'b0;
        alu_op      = 2'b00;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_last) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                unique case (1'b1)
                    op_r:  cls_d = C_OP;
                    op_i:  cls_d = C_OPI;
                    op_ld: cls_d = C_LD;
                    op_st: cls_d = C_ST;
                    op_br: cls_d = C_BR;
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_imm = cls_q inside {C_OPI, C_LD, C_ST};
                unique case (cls_q)
                    C_LD, C_ST: begin
                        alu_op  = 2'b00;
                        state_d = S_MEM;
                    end
                    C_BR: begin
                        alu_op  = 2'b01;
                        pc_en   = 1'b1;
                        pc_sel  = bus.branch_taken;
                        state_d = S_FETCH;
                    end
                    default: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (cls_q == C_ST);
                alu_src_imm = 1'b1;
                if (bus.dmem_ready) begin
                    if (cls_q == C_ST) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_last) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (cls_q == C_LD);
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_en       = ir_en;
    assign bus.pc_en       = pc_en;
    assign bus.pc_sel      = pc_sel;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.rf_we       = rf_we;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.wb_sel      = wb_sel;
    assign bus.alu_op      = alu_op;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = cause_q;
    assign bus.state_dbg   = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cyc_q, inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= 32'd0;
            inst_q <= 32'd0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (pc_en) begin
                inst_q <= inst_q + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt   = cyc_q;
    assign bus.instret_cnt = inst_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       ir_en;
        logic       pc_en;
        logic       pc_sel;
        logic       dreq;
        logic       dwe;
        logic       rf_we;
        logic       src_imm;
        logic       wb_sel;
        logic [1:0] alu_op;
        logic       trap;
        logic [1:0] cause;
    } exp_t;

    typedef struct packed {
        exp_t       e;
        logic       ir;
        logic       dr;
        logic       bt;
        logic [6:0] opc;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         ncyc = 0;
    logic       mtrap;
    logic [1:0] mcause;
    int         mcyc, minst;
    logic [6:0] cur_opc;
    logic       cur_bt;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic exp_t rec(logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e.st      = bus.state_dbg;
        e.ireq    = bus.imem_req;
        e.ir_en   = bus.ir_en;
        e.pc_en   = bus.pc_en;
        e.pc_sel  = bus.pc_sel;
        e.dreq    = bus.dmem_req;
        e.dwe     = bus.dmem_we;
        e.rf_we   = bus.rf_we;
        e.src_imm = bus.alu_src_imm;
        e.wb_sel  = bus.wb_sel;
        e.alu_op  = bus.alu_op;
        e.trap    = bus.trap;
        e.cause   = bus.trap_cause;
        return e;
    endfunction

    task automatic push(exp_t e, logic ir, logic dr);
        cyc_t c;
        c.e   = e;
        c.ir  = ir;
        c.dr  = dr;
        c.bt  = cur_bt;
        c.opc = cur_opc;
        q.push_back(c);
    endtask

    // Expands one instruction into its expected cycle-by-cycle outputs.
    task automatic plan_instr(logic [6:0] opc, int iw, int dw, logic bt);
        exp_t e;
        logic ld, st, br, legal;
        cur_opc = opc;
        cur_bt  = bt;
        ld = (opc == OPC_LD);
        st = (opc == OPC_ST);
        br = (opc == OPC_BR);
        legal = opc inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR};
        for (int k = 0; k < iw && k < TO; k++) begin
            e = rec(3'd1);
            e.ireq = 1'b1;
            push(e, 1'b0, rnd());
        end
        if (iw >= TO) begin
            mtrap = 1'b1;
            mcause = 2'b10;
            return;
        end
        e = rec(3'd1);
        e.ireq = 1'b1;
        e.ir_en = 1'b1;
        push(e, 1'b1, rnd());
        push(rec(3'd2), rnd(), rnd());
        if (!legal) begin
            mtrap = 1'b1;
            mcause = 2'b01;
            return;
        end
        e = rec(3'd3);
        e.src_imm = (opc != OPC_R) && !br;
        e.alu_op = (ld || st) ? 2'd0 : (br ? 2'd1 : 2'd2);
        if (br) begin
            e.pc_en = 1'b1;
            e.pc_sel = bt;
        end
        push(e, rnd(), rnd());
        if (br) return;
        if (ld || st) begin
            e = rec(3'd4);
            e.dreq = 1'b1;
            e.dwe = st;
            e.src_imm = 1'b1;
            for (int k = 0; k < dw && k < TO; k++) push(e, rnd(), 1'b0);
            if (dw >= TO) begin
                mtrap = 1'b1;
                mcause = 2'b11;
                return;
            end
            e.pc_en = st;
            push(e, rnd(), 1'b1);
            if (st) return;
        end
        e = rec(3'd5);
        e.rf_we = 1'b1;
        e.wb_sel = ld;
        e.pc_en = 1'b1;
        push(e, rnd(), rnd());
    endtask

    task automatic plan_trap(int n);
        exp_t e;
        e = rec(3'd6);
        e.trap = 1'b1;
        e.cause = mcause;
        for (int k = 0; k < n; k++) push(e, rnd(), rnd());
    endtask

    task automatic run_plan();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.opcode = c.opc;
            bus.imem_ready = c.ir;
            bus.dmem_ready = c.dr;
            bus.branch_taken = c.bt;
            @(negedge clk);
            ncyc++;
            chk($sformatf("cyc%0d_st%0d", ncyc, c.e.st), 32'(obs()), 32'(c.e));
            if (c.e.st != 3'd0 && c.e.st != 3'd6) mcyc++;
            if (c.e.pc_en) minst++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic perf_chk();
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("cycle_cnt", bus.cycle_cnt, 32'(mcyc));
        chk("instret_cnt", bus.instret_cnt, 32'(minst));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.opcode = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        mtrap = 1'b0;
        mcause = 2'b00;
        mcyc = 0;
        minst = 0;
        #1;
        chk("rst_outs", 32'(obs()), 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("rst_cnts", {bus.cycle_cnt[15:0], bus.instret_cnt[15:0]}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(rec(3'd0), rnd(), rnd());
    endtask

    logic [6:0] r_opc;
    int         pick, iw, dw;

    initial begin
        do_reset();
        plan_instr(OPC_I, 0, 0, 1'b0);
        run_plan();
        perf_chk();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        chk("addi_back_fetch", 32'(bus.state_dbg), 32'd1);

        do_reset();
        plan_instr(OPC_LD, 0, 3, 1'b0);
        run_plan();
        perf_chk();

        do_reset();
        plan_instr(OPC_ST, 0, 0, 1'b0);
        plan_instr(OPC_BR, 0, 0, 1'b1);
        run_plan();
        perf_chk();

        do_reset();
        plan_instr(7'b1111111, 0, 0, 1'b0);
        plan_trap(20);
        run_plan();
        do_reset();
        run_plan();

        do_reset();
        plan_instr(OPC_R, TO, 0, 1'b0);
        plan_trap(3);
        run_plan();
        do_reset();
        plan_instr(OPC_R, TO - 1, 0, 1'b0);
        run_plan();

        do_reset();
        plan_instr(OPC_LD, 1, TO, 1'b0);
        plan_trap(3);
        run_plan();

        do_reset();
        run_plan();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        chk("fetch_req", {28'd0, bus.state_dbg, bus.imem_req}, 32'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop", 32'(obs()), 32'd0);

        do_reset();
        for (int i = 0; i < 3; i++) plan_instr(OPC_I, 0, 0, 1'b0);
        run_plan();
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("perf_cyc12", bus.cycle_cnt, 32'd12);
        chk("perf_inst3", bus.instret_cnt, 32'd3);
`endif

        do_reset();
        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 19);
            if (pick < 4) r_opc = OPC_R;
            else if (pick < 8) r_opc = OPC_I;
            else if (pick < 12) r_opc = OPC_LD;
            else if (pick < 16) r_opc = OPC_ST;
            else if (pick < 19) r_opc = OPC_BR;
            else r_opc = 7'($urandom);
            iw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2)
                                              : $urandom_range(0, TO - 1);
            dw = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2)
                                              : $urandom_range(0, TO - 1);
            plan_instr(r_opc, iw, dw, rnd());
            if (mtrap) plan_trap(3);
            run_plan();
            perf_chk();
            if (mtrap) do_reset();
        end
        run_plan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
